hex_entry_display: RTL and testbench
====================================

HEX_ENTRY_DISPLAY -- requirements
Module: hex_entry_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of 7-segment digits driven (legal 1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a key change (legal >= 2).
REQ-003 SHALL have parameter BLINK_PERIOD, default 25000000, full blink period in cycles (legal even, >= 2; used only under REQ-024).
REQ-004 SHALL have port CLOCK_50  input  1  system clock, 50 MHz; the only clock; all state on its rising edge.
REQ-005 SHALL have port RESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port SW  input  4  hex value to enter, sampled when an ENTER press is accepted.
REQ-007 SHALL have port KEY_ENTER  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-008 SHALL have port KEY_CLEAR  input  1  raw pushbutton, active-low, asynchronous.
REQ-009 SHALL have port HEX  output  7*NUM_DIGITS  segments, active-low, digit i at bits [7i+6:7i], bit order g..a; digit 0 rightmost.
REQ-010 SHALL have port COUNT  output  4  number of valid digits held (0..NUM_DIGITS).
REQ-011 SHALL have port OVERFLOW  output  1  sticky flag: at least one digit shifted out.

Function
REQ-012 Each key SHALL pass a 2-flop synchronizer, then a debouncer: counter increments while synchronized level != debounced level, clears when equal; debounced level toggles when the counter reaches DEBOUNCE_CYCLES-1 while still differing.
REQ-013 An accepted press SHALL be a debounced 1->0 transition; release generates no event; a held key generates exactly one event.
REQ-014 On an ENTER event, digits SHALL shift left one position (digit i <= digit i-1), digit 0 <= SW captured at the event cycle; HEX, COUNT and OVERFLOW update on the first clock edge after the debounced level falls.
REQ-015 COUNT SHALL increment on ENTER and saturate at NUM_DIGITS.
REQ-016 ENTER with COUNT == NUM_DIGITS SHALL discard the top digit and set OVERFLOW.
REQ-017 On a CLEAR event, all digits SHALL be invalidated, COUNT <= 0, OVERFLOW <= 0.
REQ-018 CLEAR and ENTER events in the same cycle: CLEAR SHALL win; ENTER is dropped.
REQ-019 Digit positions i >= COUNT SHALL display blank (7'h7F).
REQ-020 Valid digits SHALL encode 0..F, active-low; e.g. 0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, F->7'h0E.
REQ-021 HEX SHALL be registered (no combinational path from SW or keys to HEX).

Reset
REQ-022 RESETn low SHALL asynchronously force: all digits invalid, HEX all 7'h7F, COUNT 0, OVERFLOW 0, synchronizer and debounced levels 1 (released), debounce and blink counters 0.
REQ-023 A key held low through RESETn deassertion SHALL be accepted as one press after DEBOUNCE_CYCLES, in the same way as a press arriving after reset; reset asserted mid-debounce SHALL abandon the pending change.

Configuration
REQ-024 Macro HEX_BLINK_EN: when defined, a free-running counter of period BLINK_PERIOD SHALL blank digit 0 (7'h7F) during the second half of each period whenever COUNT > 0, and the counter SHALL restart at 0 on each ENTER event; when undefined, no blink counter exists and digit 0 displays steadily; REQ-001..023 are otherwise identical.

Verification (DEBOUNCE_CYCLES=4, BLINK_PERIOD=8, NUM_DIGITS=6)
REQ-025 Reset, then 20 idle cycles -> HEX == all 7'h7F, COUNT 0, OVERFLOW 0.
REQ-026 SW=4'hA, KEY_ENTER low 10 cycles with a 1-cycle glitch high at cycle 2 -> exactly one event; digit 0 = 7'h08, COUNT 1.
REQ-027 Enter 1,2,3,4,5,6,7 -> digits 5..0 = 2,3,4,5,6,7, COUNT 6, OVERFLOW 1.
REQ-028 Both keys pressed on the same cycle with COUNT 3 -> COUNT 0, HEX all 7'h7F, OVERFLOW 0.
REQ-029 KEY_ENTER low 3 cycles then high -> no event, HEX unchanged; RESETn pulsed mid-debounce -> pending press discarded.
REQ-030 With HEX_BLINK_EN, enter F -> digit 0 = 7'h0E for 4 cycles, then 7'h7F for 4 cycles, repeating; without the macro, steady 7'h0E.

Source files
------------

// File: rtl/hex_entry_display.sv
// hex_entry_display: keypad-style hex digit entry onto a row of 7-segment
// displays. Two raw active-low pushbuttons are synchronized and debounced.
// ENTER shifts the SW nibble in at the right-hand digit. CLEAR empties the
// display. Unused digit positions are blanked.
//
// Optional build macro: HEX_BLINK_EN. When defined, digit 0 blinks with
// period BLINK_PERIOD while at least one digit is held. The blink phase
// restarts on every accepted ENTER.
//
// Key handshake: there is no valid/ready pairing on this block. Each key
// produces a single-cycle event pulse (fall_o) that the top consumes
// unconditionally in the same cycle; nothing is ever back-pressured.

// Per-key synchronizer + debouncer + falling-edge (press) detector.
module hex_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic fall_o
);

  localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Two-flop synchronizer; idles at the released level (1).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level on the last one.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounced level, its delayed copy and the stability counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // A press is a debounced 1->0 transition, seen one cycle after it happens.
  assign fall_o = prev_q & ~level_q;

endmodule

// Top: digit shift register, count/overflow bookkeeping and registered segments.
module hex_entry_display #(
  parameter int unsigned NUM_DIGITS      = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_PERIOD    = 25000000
) (
  input  logic                    CLOCK_50,
  input  logic                    RESETn,
  input  logic [3:0]              SW,
  input  logic                    KEY_ENTER,
  input  logic                    KEY_CLEAR,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic [3:0]              COUNT,
  output logic                    OVERFLOW
);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] COUNT_MAX = 4'(NUM_DIGITS);

  logic                    enter_ev;
  logic                    clear_ev;
  logic                    enter_take;
  logic [3:0]              digits_q [NUM_DIGITS];
  logic [3:0]              digits_d [NUM_DIGITS];
  logic [3:0]              count_q;
  logic [3:0]              count_d;
  logic                    ovf_q;
  logic                    ovf_d;
  logic [7*NUM_DIGITS-1:0] hex_q;
  logic [7*NUM_DIGITS-1:0] hex_d;
  logic                    blink_blank;

  // Active-low g..a encoding of one hex nibble.
  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  hex_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk_i  (CLOCK_50),
    .rst_ni (RESETn),
    .key_i  (KEY_ENTER),
    .fall_o (enter_ev)
  );

  hex_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk_i  (CLOCK_50),
    .rst_ni (RESETn),
    .key_i  (KEY_CLEAR),
    .fall_o (clear_ev)
  );

  // CLEAR has priority: a simultaneous ENTER is dropped.
  assign enter_take = enter_ev & ~clear_ev;

  // Next digit/count/overflow state from the key events.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear_ev) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits_d[i] = 4'h0;
      end
      count_d = 4'h0;
      ovf_d   = 1'b0;
    end else if (enter_take) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        digits_d[i] = digits_q[i-1];
      end
      digits_d[0] = SW;
      if (count_q == COUNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 4'h1;
      end
    end
  end

`ifdef HEX_BLINK_EN
  localparam int unsigned   BW         = $clog2(BLINK_PERIOD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_PERIOD / 2);

  logic [BW-1:0] blink_q;
  logic [BW-1:0] blink_d;

  // Free-running blink phase, restarted by every accepted ENTER.
  always_comb begin
    blink_d = blink_q + 1'b1;
    if (enter_take || (blink_q == BLINK_LAST)) begin
      blink_d = '0;
    end
  end

  // Blink phase register.
  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end

  // Second half of the period blanks digit 0 (only matters when COUNT > 0).
  assign blink_blank = (blink_d >= BLINK_HALF);
`else
  assign blink_blank = 1'b0;

  // BLINK_PERIOD only shapes the blink build; this guard keeps its legal range visible.
  if (BLINK_PERIOD < 2) begin : g_blink_period_below_min
  end
`endif

  // Segment image for the state that is about to be registered.
  always_comb begin
    hex_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (4'(i) < count_d) begin
        hex_d[7*i +: 7] = seg_encode(digits_d[i]);
      end else begin
        hex_d[7*i +: 7] = SEG_BLANK;
      end
    end
    if (blink_blank && (count_d != 4'h0)) begin
      hex_d[6:0] = SEG_BLANK;
    end
  end

  // Digit store, count, overflow and the registered segment outputs.
  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits_q[i] <= 4'h0;
      end
      count_q <= 4'h0;
      ovf_q   <= 1'b0;
      hex_q   <= '1;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      hex_q    <= hex_d;
    end
  end

  assign HEX      = hex_q;
  assign COUNT    = count_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_hex_entry_display.sv
// Bench for hex_entry_display (NUM_DIGITS=6, DEBOUNCE_CYCLES=4, BLINK_PERIOD=8).
// Reference model: a queue of entered nibbles (newest at index 0) plus a
// sticky overflow bit. Build with HEX_BLINK_EN to check the blinking variant.
module tb_hex_entry_display;

  localparam int ND = 6;
  localparam int DB = 4;
  localparam int BP = 8;
`ifdef HEX_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [3:0]      sw;
  logic            key_enter;
  logic            key_clear;
  logic [7*ND-1:0] hex;
  logic [3:0]      count;
  logic            overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_q[$];
  bit         exp_ovf;
  logic [6:0] seg_tab [16];

  hex_entry_display #(
    .NUM_DIGITS      (ND),
    .DEBOUNCE_CYCLES (DB),
    .BLINK_PERIOD    (BP)
  ) dut (
    .CLOCK_50  (clk),
    .RESETn    (rst_n),
    .SW        (sw),
    .KEY_ENTER (key_enter),
    .KEY_CLEAR (key_clear),
    .HEX       (hex),
    .COUNT     (count),
    .OVERFLOW  (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic model_enter(input logic [3:0] v);
    exp_q.push_front(v);
    if (exp_q.size() > ND) begin
      void'(exp_q.pop_back());
      exp_ovf = 1'b1;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  function automatic logic [7*ND-1:0] model_hex();
    logic [7*ND-1:0] h;
    h = '1;
    for (int i = 0; i < ND; i++) begin
      if (i < exp_q.size()) h[7*i +: 7] = seg_tab[exp_q[i]];
    end
    return h;
  endfunction

  task automatic check_all(input string tag);
    logic [7*ND-1:0] mask;
    mask = '0;
    if (BLINK) mask[6:0] = 7'h7F;  // digit 0 phase-dependent in the blink build
    check({tag, "_hex"}, 64'(hex | mask), 64'(model_hex() | mask));
    check({tag, "_count"}, 64'(count), 64'(exp_q.size()));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
  endtask

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_enter(input logic [3:0] v);
    sw = v;
    key_enter = 1'b0;
    idle(10);
    key_enter = 1'b1;
    idle(10);
    model_enter(v);
  endtask

  task automatic do_clear();
    key_clear = 1'b0;
    idle(10);
    key_clear = 1'b1;
    idle(10);
    model_clear();
  endtask

  task automatic do_both(input logic [3:0] v);
    sw = v;
    key_enter = 1'b0;
    key_clear = 1'b0;
    idle(10);
    key_enter = 1'b1;
    key_clear = 1'b1;
    idle(10);
    model_clear();
  endtask

  task automatic do_glitch(input int n);
    key_enter = 1'b0;
    idle(n);
    key_enter = 1'b1;
    idle(15);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    exp_ovf   = 1'b0;
    rst_n     = 1'b0;
    sw        = 4'h0;
    key_enter = 1'b1;
    key_clear = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    check_all("reset");

    // Glitchy press: one bounce high at cycle 2 still gives one event.
    sw = 4'hA;
    for (int c = 0; c < 10; c++) begin
      key_enter = (c == 2);
      idle(1);
    end
    key_enter = 1'b1;
    idle(10);
    model_enter(4'hA);
    check_all("glitch_press");

    // Latency: 2 sync + DEBOUNCE_CYCLES + 1 edges after the key falls.
    sw = 4'h1;
    key_enter = 1'b0;
    idle(6);
    check("latency_before", 64'(count), 64'd1);
    idle(1);
    check("latency_at", 64'(count), 64'd2);
    idle(3);
    key_enter = 1'b1;
    idle(10);
    model_enter(4'h1);

    // Fill past capacity: 2..7 on top of A,1.
    for (int v = 2; v <= 7; v++) do_enter(4'(v));
    check_all("overflow");
    check("ovf_digits", 64'(hex), 64'({7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}));

    do_clear();
    check_all("clear");

    // Three digits, then both keys at once: CLEAR wins.
    do_enter(4'h8);
    do_enter(4'hC);
    do_enter(4'h3);
    check_all("three");
    do_both(4'h9);
    check_all("both_keys");

    // Too-short press is ignored.
    do_enter(4'hE);
    do_glitch(3);
    check_all("short_press");

    // Reset in the middle of a debounce abandons the press.
    key_enter = 1'b0;
    idle(3);
    rst_n = 1'b0;
    idle(1);
    key_enter = 1'b1;
    idle(2);
    rst_n = 1'b1;
    model_clear();
    idle(20);
    check_all("reset_mid_debounce");

    // Key held through reset release counts as one press.
    sw = 4'h5;
    rst_n = 1'b0;
    key_enter = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(12);
    key_enter = 1'b1;
    idle(10);
    model_enter(4'h5);
    check_all("held_through_reset");

    // Digit 0 after entering F: steady, or blinking 4 on / 4 off.
    do_clear();
    sw = 4'hF;
    key_enter = 1'b0;
    idle(7);
    for (int k = 0; k < 2 * BP; k++) begin
      check($sformatf("blink_k%0d", k), 64'(hex[6:0]),
            64'((BLINK && ((k % BP) >= BP / 2)) ? 7'h7F : 7'h0E));
      idle(1);
    end
    key_enter = 1'b1;
    idle(10);
    model_enter(4'hF);
    check_all("after_blink");

    // Randomized operation mix against the model.
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op == 0)      do_clear();
      else if (op == 1) do_glitch($urandom_range(1, 3));
      else if (op == 2) do_both(4'($urandom_range(0, 15)));
      else              do_enter(4'($urandom_range(0, 15)));
      check_all($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
